// File: rtl/prog_loader_if.sv
// Byte-stream source and program-memory write bus
// shared between the loader and its surroundings.
interface prog_loader_if #(
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: length/payload/checksum byte stream
// into program memory; holds the core in reset meanwhile.
module prog_loader #(
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  prog_loader_if.slave   bus,
  output logic           cpu_rst,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [8:0] DEPTH_9 = 9'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        acc;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              done_q;
  logic              err_q;

  logic accept;
  logic len_ok;
  logic last;
  logic sum_ok;
  logic launch;

  assign accept = bus.in_valid & bus.in_ready;
  assign len_ok = (bus.in_data != 8'd0) &&
                  ({1'b0, bus.in_data} <= DEPTH_9);
  assign last   = (cnt == len - ONE);
  assign sum_ok = (bus.in_data == acc);
  assign launch = start &&
                  (state == S_IDLE || state == S_DONE);

  assign bus.in_ready  = busy;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign done          = done_q;
  assign err           = err_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    cpu_rst = 1'b1;
    unique case (state)
      S_IDLE: begin
        if (start) state_n = S_LEN;
      end
      S_LEN: begin
        busy = 1'b1;
        if (accept)
          state_n = len_ok ? S_DATA : S_IDLE;
      end
      S_DATA: begin
        busy = 1'b1;
        if (accept && last) state_n = S_CSUM;
      end
      S_CSUM: begin
        busy = 1'b1;
        if (accept)
          state_n = sum_ok ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        cpu_rst = 1'b0;
        if (start) state_n = S_LEN;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Session datapath: length, counter, checksum, flags
  always_ff @(posedge clk) begin
    if (rst) begin
      len    <= '0;
      cnt    <= '0;
      acc    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (launch) begin
      len    <= '0;
      cnt    <= '0;
      acc    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      unique case (state)
        S_LEN: begin
          if (len_ok) len <= CNT_W'(bus.in_data);
          else        err_q <= 1'b1;
        end
        S_DATA: begin
          cnt <= cnt + ONE;
          acc <= acc + bus.in_data;
        end
        S_CSUM: begin
          if (sum_ok) done_q <= 1'b1;
          else        err_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered memory write, one cycle after a payload byte
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= accept && (state == S_DATA);
      if (accept && state == S_DATA) begin
        addr_q  <= cnt[ADDR_W-1:0];
        wdata_q <= bus.in_data;
      end
    end
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width; program depth DEPTH = 2^ADDR_W (16).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a load session.
REQ-005 in_valid  input  1  source has a byte on in_data.
REQ-006 in_data  input  8  byte stream: length, payload, checksum.
REQ-007 in_ready  output  1  loader can accept a byte this cycle.
REQ-008 mem_we  output  1  one-cycle program-memory write strobe.
REQ-009 mem_addr  output  ADDR_W  program-memory write address.
REQ-010 mem_wdata  output  8  program-memory write data.
REQ-011 cpu_rst  output  1  holds the SAP-1 core in reset while 1.
REQ-012 busy  output  1  load session in progress.
REQ-013 done  output  1  last session completed with good checksum; sticky.
REQ-014 err  output  1  last session failed; sticky.

Function
REQ-015 Byte transfer SHALL occur only on a rising edge with in_valid=1 and in_ready=1; in_valid without in_ready SHALL be ignored.
REQ-016 FSM states SHALL be IDLE, LEN, DATA, CSUM, DONE; in_ready=1 exactly in LEN, DATA, CSUM; busy=1 exactly in LEN, DATA, CSUM.
REQ-017 IDLE/DONE: start=1 SHALL go to LEN, clear done, err, byte counter and checksum accumulator; start in LEN/DATA/CSUM SHALL be ignored.
REQ-018 LEN: accepted byte N with 1<=N<=DEPTH SHALL store N and go to DATA; N=0 or N>DEPTH SHALL set err and go to IDLE.
REQ-019 DATA: each accepted byte SHALL be written to address = counter (0,1,...,N-1), added mod 256 to the accumulator, counter incremented; after the N-th byte go to CSUM.
REQ-020 Write latency: mem_we SHALL pulse for exactly one cycle, the cycle after acceptance, with mem_addr/mem_wdata registered and valid in that same cycle.
REQ-021 Addresses SHALL never wrap within a session; counter width covers 0..DEPTH.
REQ-022 CSUM: accepted byte equal to accumulator SHALL go to DONE and set done; mismatch SHALL set err and go to IDLE.
REQ-023 cpu_rst SHALL be 1 in IDLE, LEN, DATA, CSUM; 0 only in DONE.
REQ-024 done and err SHALL never be 1 simultaneously.
REQ-025 mem_we SHALL be 0 in every cycle not following a DATA-byte acceptance.

Reset
REQ-026 rst=1 SHALL force, next edge: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, busy=0, done=0, err=0, counter/accumulator/N=0.
REQ-027 rst SHALL win over start, in_valid and any pending write; a write strobe due the cycle after rst SHALL be dropped.

Verification
REQ-028 start; bytes 0x03,0x1A,0x2B,0xF0,0x35 -> writes (0,0x1A),(1,0x2B),(2,0xF0), done=1, err=0, cpu_rst=0 from cycle after 0x35 accepted.
REQ-029 start; 0x03,0x1A,0x2B,0xF0,0x36 -> three writes, err=1, done=0, cpu_rst stays 1, state IDLE.
REQ-030 start; length 0x00 (then separately 0x11) -> err=1 next cycle, no mem_we, in_ready=0.
REQ-031 start; 0x10, payload 0x00..0x0F, checksum 0x78 -> 16 writes at addresses 0..15 in order, no wrap, done=1.
REQ-032 Scenario REQ-028 with in_valid toggled 1/0 every cycle and start pulsed during DATA -> identical writes and result; start ignored.
REQ-033 rst held one cycle after second DATA byte accepted -> no further mem_we, all outputs at reset values, subsequent full session from REQ-028 succeeds.
